// File: rtl/fll_cfg_pkg.sv
// Shared definitions for the FLL configuration responder: register map,
// FSM state type, reset defaults and address decode helper.
package fll_cfg_pkg;

    localparam logic [3:0] ADDR_STATUS = 4'h0;
    localparam logic [3:0] ADDR_CONF1  = 4'h1;
    localparam logic [3:0] ADDR_CONF2  = 4'h2;
    localparam logic [3:0] ADDR_INTEG  = 4'h3;

    localparam logic [31:0] CONF1_RST_DEF = 32'h0000_05F5;
    localparam logic [31:0] CONF2_RST_DEF = 32'h0000_0100;
    localparam logic [31:0] INTEG_RST_DEF = 32'h0000_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } fll_cfg_state_e;

    // True for the addresses that hold writable configuration registers
    function automatic logic is_rw_addr(input logic [3:0] addr);
        logic rw;
        case (addr)
            ADDR_CONF1: rw = 1'b1;
            ADDR_CONF2: rw = 1'b1;
            ADDR_INTEG: rw = 1'b1;
            default:    rw = 1'b0;
        endcase
        return rw;
    endfunction

endpackage

// File: rtl/fll_cfg_responder_if.sv
// FLL_BUS 4-phase req/ack handshake bundle between the APB-side initiator
// (master) and the FLL-domain responder (slave).
interface fll_cfg_responder_if;
    import fll_cfg_pkg::*;

    logic        req;
    logic        web;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output req,
        output web,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  web,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );

endinterface

// File: rtl/fll_cfg_req_sync.sv
// Two-flop synchroniser bringing the asynchronous request into clk_i;
// both stages clear to 0 on reset.
module fll_cfg_req_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= async_i;
            sync_r <= meta_r;
        end
    end

    assign sync_o = sync_r;

endmodule

// File: rtl/fll_cfg_responder.sv
// FLL-domain responder of the FLL_BUS configuration handshake; one register
// access per request. Define FLL_CFG_RESP_REQ_SYNC_EN to synchronise req.
module fll_cfg_responder
    import fll_cfg_pkg::*;
#(
    parameter logic [31:0] CONF1_RST = CONF1_RST_DEF,
    parameter logic [31:0] CONF2_RST = CONF2_RST_DEF,
    parameter logic [31:0] INTEG_RST = INTEG_RST_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    fll_cfg_responder_if.slave     bus,
    input  logic [31:0]            status_i,
    output logic [31:0]            conf1_o,
    output logic [31:0]            conf2_o,
    output logic [31:0]            integ_o,
    output logic                   upd_o,
    output logic [3:0]             upd_addr_o
);

    logic            req_s;
    fll_cfg_state_e  state_r;
    fll_cfg_state_e  state_nxt_s;
    logic            access_s;
    logic            wr_s;
    logic            rd_s;
    logic [31:0]     rd_mux_s;

    logic            ack_r;
    logic [31:0]     rdata_r;
    logic            upd_r;
    logic [3:0]      upd_addr_r;
    logic [31:0]     conf1_r;
    logic [31:0]     conf2_r;
    logic [31:0]     integ_r;

`ifdef FLL_CFG_RESP_REQ_SYNC_EN
    fll_cfg_req_sync u_req_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (bus.req),
        .sync_o  (req_s)
    );
`else
    assign req_s = bus.req;
`endif

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: one access per request, then wait for req to drop
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_s) begin
                    state_nxt_s = ACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACK;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: access strobes and read-data selection
    always_comb begin
        access_s = (state_r == IDLE) && req_s;
        wr_s     = access_s && !bus.web && is_rw_addr(bus.addr);
        rd_s     = access_s && bus.web;
        case (bus.addr)
            ADDR_STATUS: rd_mux_s = status_i;
            ADDR_CONF1:  rd_mux_s = conf1_r;
            ADDR_CONF2:  rd_mux_s = conf2_r;
            ADDR_INTEG:  rd_mux_s = integ_r;
            default:     rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Handshake outputs; ack follows the next state so it is flop-driven
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ack_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            upd_r      <= 1'b0;
            upd_addr_r <= 4'h0;
        end else begin
            ack_r <= (state_nxt_s == ACK);
            upd_r <= wr_s;
            if (wr_s) begin
                upd_addr_r <= bus.addr;
            end
            if (rd_s) begin
                rdata_r <= rd_mux_s;
            end
        end
    end

    // Configuration register file
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conf1_r <= CONF1_RST;
            conf2_r <= CONF2_RST;
            integ_r <= INTEG_RST;
        end else if (wr_s) begin
            case (bus.addr)
                ADDR_CONF1: conf1_r <= bus.wdata;
                ADDR_CONF2: conf2_r <= bus.wdata;
                ADDR_INTEG: integ_r <= bus.wdata;
                default: ;
            endcase
        end
    end

    assign bus.ack    = ack_r;
    assign bus.rdata  = rdata_r;
    assign upd_o      = upd_r;
    assign upd_addr_o = upd_addr_r;
    assign conf1_o    = conf1_r;
    assign conf2_o    = conf2_r;
    assign integ_o    = integ_r;

endmodule

// File: tb/tb_fll_cfg_responder.sv
// Self-checking bench for fll_cfg_responder: directed handshakes plus random
// accesses, checked against a register-map model every cycle.
module tb_fll_cfg_responder;

`ifdef FLL_CFG_RESP_REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] status;
    logic [31:0] conf1, conf2, integ;
    logic        upd;
    logic [3:0]  upd_addr;

    fll_cfg_responder_if bus ();

    fll_cfg_responder dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .bus        (bus),
        .status_i   (status),
        .conf1_o    (conf1),
        .conf2_o    (conf2),
        .integ_o    (integ),
        .upd_o      (upd),
        .upd_addr_o (upd_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: register array indexed by address, last read data
    logic [31:0] m_regs [0:15];
    logic [31:0] m_rdata;
    logic        m_upd;
    logic [3:0]  m_upd_addr;
    logic        cmp_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [3:0] a);
        if (a == 4'd0) return status;
        if (a >= 4'd1 && a <= 4'd3) return m_regs[a];
        return 32'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
        m_regs[1]  = 32'h0000_05F5;
        m_regs[2]  = 32'h0000_0100;
        m_regs[3]  = 32'h0000_0000;
        m_rdata    = 32'h0;
        m_upd      = 1'b0;
        m_upd_addr = 4'h0;
    endtask

    // Every-cycle comparison of all data outputs against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("conf1", conf1, m_regs[1]);
            check("conf2", conf2, m_regs[2]);
            check("integ", integ, m_regs[3]);
            check("rdata", bus.rdata, m_rdata);
            check("upd", {31'h0, upd}, {31'h0, m_upd});
            check("upd_addr", {28'h0, upd_addr}, {28'h0, m_upd_addr});
        end
    end

    task automatic wait_ack(input logic level, output int n);
        n = 0;
        while (bus.ack !== level && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Apply the model's view of an access performed on the ack-rising edge
    task automatic model_access(input logic web, input logic [3:0] a, input logic [31:0] wd);
        if (!web) begin
            if (a >= 4'd1 && a <= 4'd3) begin
                m_regs[a]  = wd;
                m_upd      = 1'b1;
                m_upd_addr = a;
            end
        end else begin
            m_rdata = model_read(a);
        end
    endtask

    task automatic do_access(input logic web, input logic [3:0] a, input logic [31:0] wd, input int hold);
        int n;
        bus.web   = web;
        bus.addr  = a;
        bus.wdata = wd;
        bus.req   = 1'b1;
        wait_ack(1'b1, n);
        check("ack_rise_lat", n, LAT);
        model_access(web, a, wd);
        @(posedge clk); #1;
        m_upd = 1'b0;
        check("ack_held", {31'h0, bus.ack}, 32'h1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("ack_held", {31'h0, bus.ack}, 32'h1);
        end
        bus.req = 1'b0;
        wait_ack(1'b0, n);
        check("ack_fall_lat", n, LAT);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        bus.req   = 1'b0;
        bus.web   = 1'b1;
        bus.addr  = 4'h0;
        bus.wdata = 32'h0;
        status    = 32'h0;
        cmp_en    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_upd", {31'h0, upd}, 32'h0);
        check("rst_conf1", conf1, 32'h0000_05F5);
        check("rst_conf2", conf2, 32'h0000_0100);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(posedge clk); #1;

        // Read of CONF1 after reset
        do_access(1'b1, 4'h1, 32'h0, 1);
        check("read_conf1_rst", bus.rdata, 32'h0000_05F5);

        // Write then read back CONF2
        do_access(1'b0, 4'h2, 32'hDEAD_BEEF, 0);
        check("conf2_written", conf2, 32'hDEAD_BEEF);
        check("upd_addr_conf2", {28'h0, upd_addr}, 32'h2);
        do_access(1'b1, 4'h2, 32'h0, 0);
        check("read_conf2", bus.rdata, 32'hDEAD_BEEF);

        // Writes to RO and unmapped addresses; reads of those
        status = 32'hA5A5_0001;
        do_access(1'b0, 4'h0, 32'h1234_5678, 0);
        do_access(1'b0, 4'h9, 32'h1234_5678, 0);
        check("upd_addr_unchanged", {28'h0, upd_addr}, 32'h2);
        do_access(1'b1, 4'h9, 32'h0, 0);
        check("read_unmapped", bus.rdata, 32'h0);
        do_access(1'b1, 4'h0, 32'h0, 0);
        check("read_status", bus.rdata, 32'hA5A5_0001);

        // Long-held request on an INTEG write
        do_access(1'b0, 4'h3, 32'h0BAD_F00D, 20);
        check("integ_written", integ, 32'h0BAD_F00D);

        // Random accesses
        for (int t = 0; t < 40; t++) begin
            status = $urandom;
            do_access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        // Reset in the middle of a handshake with the request kept high
        do_access(1'b0, 4'h1, 32'h0000_0001, 0);
        bus.web  = 1'b1;
        bus.addr = 4'h1;
        bus.req  = 1'b1;
        wait_ack(1'b1, n);
        check("pre_rst_ack_lat", n, LAT);
        model_access(1'b1, 4'h1, 32'h0);
        check("pre_rst_rdata", bus.rdata, 32'h0000_0001);
        @(posedge clk); #2;
        cmp_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_mid_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_mid_conf1", conf1, 32'h0000_05F5);
        model_reset();
        @(posedge clk); #1;
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        wait_ack(1'b1, n);
        check("reexec_ack_lat", n, LAT);
        model_access(1'b1, 4'h1, 32'h0);
        check("reexec_rdata", bus.rdata, 32'h0000_05F5);
        @(posedge clk); #1;
        bus.req = 1'b0;
        wait_ack(1'b0, n);
        check("reexec_fall_lat", n, LAT);
        repeat (3) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fll_cfg_responder.md
# fll_cfg_responder

Responder end of the FLL_BUS 4-phase req/ack configuration handshake, sitting inside the FLL clock domain opposite the APB-side initiator. It synchronises the incoming request, performs one register read or write per handshake, and drives the data and ack back. It holds the FLL configuration registers, exposes them to the FLL core, and returns live status on reads.

## Interface
Parameters:
- CONF1_RST, default 32'h0000_05F5: reset value of CONF1.
- CONF2_RST, default 32'h0000_0100: reset value of CONF2.
- INTEG_RST, default 32'h0000_0000: reset value of INTEG.

Ports:
- clk_i  in  1  FLL reference-domain clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  request from the initiator; asynchronous to clk_i.
- web_i  in  1  write-enable, active-low: 0 = write, 1 = read. Stable while req_i is high.
- addr_i  in  4  word address. Stable while req_i is high.
- wdata_i  in  32  write data. Stable while req_i is high.
- rdata_o  out  32  read data, registered.
- ack_o  out  1  acknowledge, registered.
- status_i  in  32  live FLL status, returned on reads of address 0x0.
- conf1_o, conf2_o, integ_o  out  32 each  current register values.
- upd_o  out  1  one-cycle pulse on every accepted write to a RW register.
- upd_addr_o  out  4  address of the last accepted write.

## Operation
- Register map:
  - 0x0 STATUS, RO, reads status_i.
  - 0x1 CONF1, RW.
  - 0x2 CONF2, RW.
  - 0x3 INTEG, RW.
  - 0x4–0xF unmapped: reads return 0, writes are ignored.
- req_i passes through a 2-flop synchroniser to give req_s.
- FSM states: IDLE, ACK.
  - IDLE, req_s=1: perform the access in this cycle, then go to ACK.
    - Write (web_i=0) to a RW register: register ← wdata_i, upd_o=1, upd_addr_o ← addr_i.
    - Read: rdata_o ← selected value.
  - ACK: ack_o=1. When req_s=0, go to IDLE and drop ack_o.
- rdata_o holds its value until the next read completes. Writes do not modify rdata_o.
- Writes to RO or unmapped addresses still complete the full handshake with no side effect and no upd_o pulse.
- Exactly one access is performed per req rising edge. A req_i held high never re-triggers the access.
- Reset values: ack_o=0, rdata_o=0, upd_o=0, upd_addr_o=0, state IDLE, registers at their *_RST values.
- Reset mid-handshake: ack_o drops immediately. If req_i is still high after reset release, the access is executed again; a repeated write is idempotent.

## Timing
- With synchronisation, req_i rising to ack_o rising is 3 clk_i edges: 2 sync edges, then the FSM edge.
- On that same third edge: rdata_o is valid, the register write takes effect, and upd_o is high for exactly 1 cycle.
- req_i falling to ack_o falling is 3 edges.
- ack_o is glitch-free: driven straight from a flop.
- rdata_o is stable for the whole period ack_o is high, because the initiator samples it after its own ack synchronisation.
- Minimum handshake cycle, measured in clk_i: 6 edges plus the initiator's turnaround.
- status_i is sampled on the access edge. Status is not synchronised inside this block.

## Configuration
- Macro: FLL_CFG_RESP_REQ_SYNC_EN.
- Defined: 2-flop req_i synchroniser present; latencies are as in Timing (3 edges up, 3 edges down).
- Undefined: req_s = req_i directly, for same-clock integrations. Latency becomes 1 edge to ack_o rising and 1 edge to ack_o falling; all other behaviour is identical.

## Structure
- Package fll_cfg_pkg contains:
  - address constants: ADDR_STATUS=4'h0, ADDR_CONF1=4'h1, ADDR_CONF2=4'h2, ADDR_INTEG=4'h3;
  - the FSM state typedef (IDLE, ACK);
  - default reset-value constants.
- Sub-module fll_cfg_req_sync: 2-flop synchroniser with asynchronous reset to 0. It is instantiated only when FLL_CFG_RESP_REQ_SYNC_EN is defined.

## Test plan
- Reset, then read 0x1 → ack_o rises 3 edges after req_i; rdata_o=32'h0000_05F5; ack_o falls 3 edges after req_i drops.
- Write 0x2 with 32'hDEAD_BEEF, then read 0x2 → conf2_o=32'hDEAD_BEEF; upd_o is a single-cycle pulse with upd_addr_o=4'h2; the read returns 32'hDEAD_BEEF.
- Write 32'h1234_5678 to 0x0 and to 0x9 → full handshake completes; no upd_o; a read of 0x9 returns 0; a read of 0x0 returns status_i (drive 32'hA5A5_0001).
- Hold req_i high for 20 cycles on a write to 0x3 → exactly one upd_o pulse; ack_o stays high until req_i drops.
- Assert rst_ni low while ack_o=1 with CONF1 previously written to 32'h1 → ack_o goes to 0 immediately; conf1_o=32'h0000_05F5; with req_i kept high, the access re-executes after reset release.
- Build with the macro undefined → ack_o rises 1 edge after req_i and falls 1 edge after req_i drops.
